// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clock divider controller.
//   state_e : controller FSM encoding (STOP / RUN / PEND)
//   MIN_DIV : smallest divisor the divider can produce
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter plus posedge/negedge phase flops.
//   clk_i      : input clock
//   rst_ni     : asynchronous active-low reset
//   run_i      : count enable; when low the counter and both phases sit at 0
//   div_i      : divisor N currently in effect (N >= 2)
//   cnt_o      : period counter, 0..N-1
//   boundary_o : high during the last cycle of a period (cnt == N-1 while running)
//   clk_o      : divided clock, period N, 50% duty (odd N uses the half cycle)
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [DIV_W-1:0] cnt_o,
    output logic             boundary_o,
    output logic             clk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half, last, rise_at;
    logic             odd, tog;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q, clk_n_d;

    assign half    = div_i >> 1;
    assign last    = div_i - DIV_W'(1);
    assign odd     = div_i[0];
    // Even N rises one cycle earlier so the high phase is exactly H cycles;
    // odd N rises at H and the negedge copy stretches it by half a cycle.
    assign rise_at = odd ? half : (half - DIV_W'(1));
    assign tog     = run_i && ((cnt_q == rise_at) || (cnt_q == last));

    assign boundary_o = run_i && (cnt_q == last);

    always_comb begin
        cnt_d   = '0;
        clk_p_d = 1'b0;
        clk_n_d = 1'b0;
        if (run_i) begin
            cnt_d   = boundary_o ? '0 : cnt_q + DIV_W'(1);
            clk_p_d = tog ? ~clk_p_q : clk_p_q;
            // The negedge flop only matters for odd divisors.
            if (odd) begin
                clk_n_d = tog ? ~clk_n_q : clk_n_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            clk_p_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_p_q <= clk_p_d;
        end
    end

    // Samples the same toggle condition half a cycle later; it rises before
    // clk_p and falls half a cycle before the period boundary.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    assign cnt_o = cnt_q;
    assign clk_o = clk_p_q | clk_n_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop sequencing and glitch-free ratio change.
//   clk_in      : sole clock
//   rst         : asynchronous active-low reset
//   clk_en      : level run request
//   div_req     : ratio-change request (pulse or level), qualified by div_val
//   div_val     : requested divisor
//   div_ack     : one-cycle pulse, new divisor now in effect
//   div_err     : one-cycle pulse, request rejected (div_val < 2)
//   div_busy    : change accepted, waiting for the period boundary
//   cur_div     : divisor in effect
//   clk_out     : divided clock
//   dbg_state_o : FSM state
//   dbg_cnt_o   : period counter
//
// Request handshake: a request is taken on any posedge where div_req is high
// and div_busy is low. A valid divisor raises div_busy the next cycle (RUN)
// and div_ack pulses when it takes effect; an invalid divisor gives a
// div_err pulse the next cycle. Requests seen while div_busy is high are
// dropped silently. In STOP a valid request is applied at once (div_ack the
// next cycle, div_busy never rises).
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             div_busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output state_e           dbg_state_o,
    output logic [DIV_W-1:0] dbg_cnt_o
);

    localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_DIV_W = DIV_W'(DEF_DIV);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             boundary, accept;

    assign accept = div_req && !busy_q && (div_val >= MIN_DIV_W);

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk_i      (clk_in),
        .rst_ni     (rst),
        .run_i      (state_q != ST_STOP),
        .div_i      (cur_div_q),
        .cnt_o      (dbg_cnt_o),
        .boundary_o (boundary),
        .clk_o      (clk_out)
    );

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_STOP;
            cur_div_q <= DEF_DIV_W;
            pend_q    <= DEF_DIV_W;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Next state: leaving RUN/PEND only ever happens at a period boundary
    // so the last period is never truncated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (clk_en) state_d = ST_RUN;
            ST_RUN: begin
                if (boundary && !clk_en) state_d = ST_STOP;
                else if (accept)         state_d = ST_PEND;
            end
            ST_PEND: if (boundary) state_d = clk_en ? ST_RUN : ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Outputs and divisor bookkeeping
    always_comb begin
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        err_d     = div_req && !busy_q && (div_val < MIN_DIV_W);
        busy_d    = busy_q;
        case (state_q)
            ST_STOP: begin
                if (accept) begin
                    cur_div_d = div_val;
                    pend_d    = div_val;
                    ack_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    pend_d = div_val;
                    // Stopping at this boundary anyway: both phases are low
                    // and the counter restarts, so apply immediately.
                    if (boundary && !clk_en) begin
                        cur_div_d = div_val;
                        ack_d     = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    cur_div_d = pend_q;
                    ack_d     = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign div_ack     = ack_q;
    assign div_err     = err_q;
    assign div_busy    = busy_q;
    assign cur_div     = cur_div_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
  import clk_div_ctrl_pkg::*;

  localparam int DIV_W = 8;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  always #5 clk_in = ~clk_in;

  logic             clk_en = 1'b0;
  logic             div_req = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_ack, div_err, div_busy, clk_out;
  logic [DIV_W-1:0] cur_div, dbg_cnt_o;
  state_e           dbg_state_o;

  int checks = 0;
  int failures = 0;

  clk_div_ctrl #(.DIV_W(DIV_W), .DEF_DIV(7)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_en      (clk_en),
    .div_req     (div_req),
    .div_val     (div_val),
    .div_ack     (div_ack),
    .div_err     (div_err),
    .div_busy    (div_busy),
    .cur_div     (cur_div),
    .clk_out     (clk_out),
    .dbg_state_o (dbg_state_o),
    .dbg_cnt_o   (dbg_cnt_o)
  );

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic half();
    @(clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // measures one clk_out cycle in half clk_in periods, starting at a rise
  task automatic measure(input string tag, input int exp_hi, input int exp_per);
    int hi, per, guard;
    hi = 0; per = 0; guard = 0;
    while (clk_out !== 1'b0 && guard < 400) begin half(); guard++; end
    while (clk_out !== 1'b1 && guard < 400) begin half(); guard++; end
    while (clk_out === 1'b1 && guard < 400) begin half(); hi++; guard++; end
    per = hi;
    while (clk_out === 1'b0 && guard < 400) begin half(); per++; guard++; end
    chk({tag, "_hi_halves"}, hi, exp_hi);
    chk({tag, "_period_halves"}, per, exp_per);
  endtask

  task automatic wait_cnt(input string tag, input int v);
    int guard;
    guard = 0;
    while (int'(dbg_cnt_o) != v && guard < 50) begin step(); guard++; end
    chk({tag, "_cnt_reached"}, int'(dbg_cnt_o), v);
  endtask

  task automatic wait_ack(input string tag);
    int guard;
    guard = 0;
    while (div_ack !== 1'b1 && guard < 50) begin step(); guard++; end
    chk({tag, "_ack_seen"}, div_ack, 1);
  endtask

  initial begin
    int n;

    // reset state
    repeat (3) step();
    chk("rst_cur_div", cur_div, 7);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_ack", div_ack, 0);
    chk("rst_err", div_err, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_state", dbg_state_o, ST_STOP);
    chk("rst_cnt", dbg_cnt_o, 0);

    // release mid-cycle: nothing changes before the next posedge
    rst = 1'b1;
    clk_en = 1'b1;
    #1;
    chk("rel_state_hold", dbg_state_o, ST_STOP);
    step();
    chk("start_state", dbg_state_o, ST_RUN);
    chk("start_cnt", dbg_cnt_o, 0);
    measure("n7", 7, 14);
    chk("n7_cur_div", cur_div, 7);

    // ratio change 7 -> 4 requested mid-period
    wait_cnt("chg4", 2);
    div_req = 1'b1; div_val = 8'd4;
    step();
    div_req = 1'b0;
    chk("chg4_busy", div_busy, 1);
    chk("chg4_state", dbg_state_o, ST_PEND);
    chk("chg4_no_early_ack", div_ack, 0);
    chk("chg4_old_div", cur_div, 7);
    wait_ack("chg4");
    chk("chg4_cur_div", cur_div, 4);
    chk("chg4_busy_clr", div_busy, 0);
    chk("chg4_cnt0", dbg_cnt_o, 0);
    chk("chg4_clk_low", clk_out, 0);
    step();
    chk("chg4_ack_one_cycle", div_ack, 0);
    measure("n4", 4, 8);

    // invalid request
    div_req = 1'b1; div_val = 8'd1;
    step();
    div_req = 1'b0;
    chk("bad_err", div_err, 1);
    chk("bad_busy", div_busy, 0);
    chk("bad_cur_div", cur_div, 4);
    step();
    chk("bad_err_one_cycle", div_err, 0);

    // requests while busy are dropped
    wait_cnt("busy", 0);
    div_req = 1'b1; div_val = 8'd5;
    step();
    chk("busy_set", div_busy, 1);
    div_val = 8'd1;
    step();
    chk("busy_ign_err", div_err, 0);
    div_val = 8'd3;
    step();
    chk("busy_ign_ack", div_ack, 0);
    chk("busy_still", div_busy, 1);
    div_req = 1'b0;
    wait_ack("n5");
    chk("n5_cur_div", cur_div, 5);
    measure("n5", 5, 10);

    // clk_en dropped mid-period: period completes
    wait_cnt("stop", 2);
    clk_en = 1'b0;
    n = 0;
    while (dbg_state_o != ST_STOP && n < 20) begin step(); n++; end
    chk("stop_cycles", n, 3);
    chk("stop_clk_low", clk_out, 0);
    repeat (3) step();
    chk("stop_cnt_held", dbg_cnt_o, 0);
    chk("stop_clk_held", clk_out, 0);
    clk_en = 1'b1;
    step();
    chk("restart_state", dbg_state_o, ST_RUN);
    chk("restart_cnt0", dbg_cnt_o, 0);
    step();
    chk("restart_cnt1", dbg_cnt_o, 1);

    // change while stopped applies at once
    clk_en = 1'b0;
    n = 0;
    while (dbg_state_o != ST_STOP && n < 20) begin step(); n++; end
    chk("stop2_reached", dbg_state_o, ST_STOP);
    div_req = 1'b1; div_val = 8'd6;
    step();
    div_req = 1'b0;
    chk("stop_chg_ack", div_ack, 1);
    chk("stop_chg_cur_div", cur_div, 6);
    chk("stop_chg_state", dbg_state_o, ST_STOP);
    chk("stop_chg_busy", div_busy, 0);
    clk_en = 1'b1;
    measure("n6", 6, 12);

    // reset in PEND discards the change
    div_req = 1'b1; div_val = 8'd3;
    step();
    div_req = 1'b0;
    chk("pend_busy", div_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cur_div", cur_div, 7);
    chk("arst_busy", div_busy, 0);
    chk("arst_clk", clk_out, 0);
    chk("arst_ack", div_ack, 0);
    chk("arst_state", dbg_state_o, ST_STOP);
    chk("arst_cnt", dbg_cnt_o, 0);
    repeat (2) step();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (div_ack === 1'b1) n++;
    end
    chk("arst_no_ack", n, 0);
    chk("arst_div_kept", cur_div, 7);
    measure("n7_again", 7, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
